// File: rtl/fifo_word_packer_if.sv
// Handshake bundle between the byte FIFO read side, the word packer and its consumer.
// master = packer side, slave = FIFO/consumer environment side.
interface fifo_word_packer_if #(
  parameter int DATA_W = 8,
  parameter int N      = 4,
  parameter int CNT_W  = $clog2(N + 1)
);
  logic                  fifo_empty;
  logic [DATA_W-1:0]     fifo_dout;
  logic                  fifo_rd_en;
  logic                  flush;
  logic [N*DATA_W-1:0]   out_data;
  logic [CNT_W-1:0]      out_cnt;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  fifo_empty, fifo_dout, flush, out_ready,
    output fifo_rd_en, out_data, out_cnt, out_valid
  );

  modport slave (
    output fifo_empty, fifo_dout, flush, out_ready,
    input  fifo_rd_en, out_data, out_cnt, out_valid
  );
endinterface

// File: rtl/fifo_word_packer.sv
// Drains DATA_W-bit entries from a 1-cycle-latency FIFO and packs N of them into one word.
// Define PACKER_FLUSH_EN to let a flush pulse emit a partially filled word.
module fifo_word_packer #(
  parameter int DATA_W = 8,
  parameter int N      = 4,
  parameter int CNT_W  = $clog2(N + 1)
) (
  input  logic               clk,
  input  logic               rst,
  fifo_word_packer_if.master bus
);
  // state | meaning
  // FILL  | issuing FIFO reads and capturing returned entries into buf_q
  // OUT   | packed word presented downstream, no FIFO reads issued
  typedef enum logic {FILL, OUT} state_e;

  state_e              state_d, state_q;
  logic [CNT_W-1:0]    cnt_d, cnt_q;
  logic                pend_d, pend_q;
  logic                flush_d, flush_q;
  logic [N*DATA_W-1:0] buf_d, buf_q;
  logic [CNT_W:0]      occ;
  logic                rd_en;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      flush_q <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      flush_q <= flush_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    flush_d = flush_q;
    buf_d   = buf_q;
    // occupancy counts the in-flight read so buf can never be overfilled
    occ     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, pend_q};
    rd_en   = rst && (state_q == FILL) && !bus.fifo_empty &&
              (occ < (CNT_W+1)'(N)) && !flush_q;

    case (state_q)
      FILL: begin
        pend_d = rd_en;
        if (pend_q) begin
          for (int i = 0; i < N; i++) begin
            if (cnt_q == CNT_W'(i)) buf_d[i*DATA_W +: DATA_W] = bus.fifo_dout;
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (pend_q && (cnt_q == CNT_W'(N - 1))) begin
          state_d = OUT;
          flush_d = 1'b0;
        end
`ifdef PACKER_FLUSH_EN
        else if (flush_q && !pend_q) begin
          state_d = OUT;
          flush_d = 1'b0;
        end else if (bus.flush && (occ != '0)) begin
          flush_d = 1'b1;
        end
`endif
      end
      OUT: begin
        if (bus.out_ready) begin
          state_d = FILL;
          cnt_d   = '0;
          buf_d   = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

`ifndef PACKER_FLUSH_EN
  logic unused_flush;
  assign unused_flush = bus.flush;
`endif

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_valid  = (state_q == OUT);
  assign bus.out_data   = (state_q == OUT) ? buf_q : '0;
  assign bus.out_cnt    = (state_q == OUT) ? cnt_q : '0;
endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Read-side consumer for the byte FIFO: drains `DATA_W`-bit entries from the FIFO and packs `N` consecutive entries into one `N*DATA_W`-bit word. It presents each word downstream on a valid/ready handshake. It sits directly downstream of the FIFO, driving its `rd_en` and consuming its `dout` and `empty`. The FIFO has a 1-cycle read latency: `dout` is valid the cycle after `rd_en` is asserted.

## Interface
- `DATA_W`, 8, width of one FIFO entry.
- `N`, 4, entries per packed word; N ≥ 2.
- `CNT_W`, $clog2(N+1), width of entry counters.

- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-low reset (asserted when 0).
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_dout`  in  DATA_W  FIFO read data, valid 1 cycle after `fifo_rd_en`.
- `fifo_rd_en`  out  1  FIFO read strobe (combinational from registered state and `fifo_empty`).
- `flush`  in  1  single-cycle request to emit a partial word (used only with `PACKER_FLUSH_EN`).
- `out_data`  out  N*DATA_W  packed word. Entry 0 (first read) is in bits [DATA_W-1:0].
- `out_cnt`  out  CNT_W  number of valid entries in `out_data`.
- `out_valid`  out  1  word available.
- `out_ready`  in  1  downstream accepts the word.

## Operation
- Registered state:
  - `state` ∈ {FILL, OUT}
  - `cnt` (entries captured)
  - `pend` (read issued, data arrives next cycle)
  - `flush_q` (latched flush request)
  - `buf` (N*DATA_W)
- Reset (rst=0 at an edge):
  - state=FILL; cnt=0; pend=0; flush_q=0; buf=0.
  - Outputs: out_valid=0, out_data=0, out_cnt=0, fifo_rd_en=0.
- `fifo_rd_en` = (state==FILL) && !fifo_empty && (cnt+pend < N) && !flush_q.
- Each edge in FILL:
  - `pend` ← fifo_rd_en.
  - If pend=1, fifo_dout is written to buf slot `cnt`, and cnt ← cnt+1.
- FILL → OUT when the captured entry makes cnt reach N.
- OUT state:
  - out_valid=1; out_data=buf; out_cnt=cnt.
  - No FIFO reads are issued.
- OUT → FILL on out_valid && out_ready. On that transition, cnt←0 and buf←0.
- out_data and out_cnt hold stable while out_valid=1 and out_ready=0.
- Slots not yet written in buf are 0.
- Reset mid-operation:
  - Any in-flight read is discarded; the entry is lost, which is the accepted behaviour.
  - A partially packed word is discarded.
- `fifo_empty` asserting mid-fill stalls reads; cnt holds; reads resume when it deasserts.
- `out_ready` is ignored while out_valid=0.

## Timing
- Back-to-back reads at 1 entry/cycle in FILL with a non-empty FIFO.
- For N=4, with the first rd_en in cycle 0:
  - rd_en is high in cycles 0–3.
  - Captures happen at the ends of cycles 1–4.
  - out_valid rises in cycle 5.
- Latency from first read to out_valid: N+1 cycles.
- With out_ready held high:
  - out_valid lasts exactly 1 cycle.
  - The next read is issued in the following cycle.
  - Minimum word period is N+2 cycles.
- fifo_rd_en is never asserted when fifo_empty=1. It is never asserted when it would overfill buf (cnt+pend=N).

## Configuration
- `PACKER_FLUSH_EN` defined:
  - A `flush` pulse in FILL with cnt+pend > 0 sets flush_q. flush_q blocks new reads.
  - Once pend=0 and flush_q=1, the next edge moves to OUT with out_cnt=cnt (< N). Upper slots are 0.
  - flush_q clears on entering OUT.
  - flush with cnt+pend=0, or in OUT, is ignored.
  - If the flushed capture completes a full word, the result is a normal full word (out_cnt=N).
- Not defined:
  - `flush` is ignored and flush_q stays 0.
  - out_cnt always equals N when out_valid=1.

## Test plan
- **Reset:** hold rst=0 for 3 cycles with fifo_empty=0 → fifo_rd_en=0, out_valid=0, out_data=0 throughout.
- **Full word:** FIFO preloaded with 0x03,0x04,0x05,0x06 and out_ready=1:
  - rd_en is high in cycles 0–3.
  - out_valid is high in cycle 5 only, with out_data=0x06050403 and out_cnt=4.
- **Empty stall:** FIFO holds 0x03,0x04, then goes empty for 5 cycles, then 0x05,0x06 are written:
  - No rd_en while empty; cnt holds at 2.
  - Final out_data=0x06050403.
- **Backpressure:** complete a word with out_ready=0 for 4 cycles:
  - out_valid and out_data stay stable and rd_en=0.
  - After out_ready=1, exactly one handshake occurs and the next read is issued the following cycle.
- **Flush (`PACKER_FLUSH_EN`):** after capturing 0x06,0x07, pulse flush → out_valid with out_data=0x00000706 and out_cnt=2.
  - Without the macro, the same stimulus produces no out_valid.
- **Reset mid-fill:** rst=0 for 1 cycle after 2 entries are captured → cnt=0 and buf=0.
  - Next 4 entries 0x0A..0x0D give out_data=0x0D0C0B0A.
